a_sqrtb_arbiter: RTL and testbench

Round-robin scheduler that shares one `a_sqrtb` datapath (8-bit a, 8-bit b in; 12-bit y out) among N independent requesters. It sits between the requester logic and the single `a_sqrtb` instance. For each job it grants one requester, resets the datapath, issues the start pulse and waits for `y_ready`. It then returns the 12-bit result, or a timeout error, to the granted requester. A watchdog guarantees forward progress if the datapath never reports ready.

---
 rtl/a_sqrtb_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_a_sqrtb_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a_sqrtb_arbiter.sv
// Round-robin scheduler sharing one a_sqrtb datapath among N requesters:
// grant, reset datapath, start, wait for ready (with watchdog), return result.
module a_sqrtb_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [8*N-1:0]   req_a,
  input  logic [8*N-1:0]   req_b,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     resp_valid,
  output logic [11:0]      resp_y,
  output logic             resp_err,
  output logic             busy,
  output logic [15:0]      done_cnt,
  output logic             dut_rst,
  output logic             dut_start,
  output logic [7:0]       dut_a,
  output logic [7:0]       dut_b,
  input  logic [11:0]      dut_y,
  input  logic             dut_ready
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);
  localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] cur_q, cur_d;
  logic [7:0]    timer_q, timer_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  rv_q, rv_d;
  logic [11:0]   resp_y_q, resp_y_d;
  logic          resp_err_q, resp_err_d;
  logic          busy_q, busy_d;
  logic [15:0]   done_q, done_d;
  logic          drst_q, drst_d;
  logic          dstart_q, dstart_d;
  logic [7:0]    a_q, a_d;
  logic [7:0]    b_q, b_d;

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;

  // Scan from last+1 with wrap; the first set bit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(last_q) + k) % N);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cur_d      = cur_q;
    timer_d    = timer_q;
    gnt_d      = '0;
    rv_d       = '0;
    resp_y_d   = resp_y_q;
    resp_err_d = resp_err_q;
    done_d     = done_q;
    drst_d     = drst_q;
    dstart_d   = dstart_q;
    a_d        = a_q;
    b_d        = b_q;

    case (state_q)
      S_IDLE: begin
        drst_d = 1'b0;
        if (win_found) begin
          gnt_d[win_idx] = 1'b1;
          drst_d         = 1'b1;
          a_d            = req_a[32'(win_idx)*8 +: 8];
          b_d            = req_b[32'(win_idx)*8 +: 8];
          cur_d          = win_idx;
          last_d         = win_idx;
          state_d        = S_RST;
        end
      end
      S_RST: begin
        drst_d   = 1'b0;
        dstart_d = 1'b1;
        state_d  = S_START;
      end
      S_START: begin
        dstart_d = 1'b0;
        timer_d  = '0;
        state_d  = S_WAIT;
      end
      // The response is registered on WAIT exit so resp_valid is high during DONE.
      S_WAIT: begin
        if (dut_ready) begin
          resp_y_d    = dut_y;
          resp_err_d  = 1'b0;
          rv_d[cur_q] = 1'b1;
          done_d      = done_q + 16'd1;
          state_d     = S_DONE;
        end else if (timer_q == TMO_LAST) begin
          resp_y_d    = '0;
          resp_err_d  = 1'b1;
          rv_d[cur_q] = 1'b1;
          done_d      = done_q + 16'd1;
          state_d     = S_DONE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_DONE: begin
        resp_err_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_q     <= LAST_RST;
      cur_q      <= '0;
      timer_q    <= '0;
      gnt_q      <= '0;
      rv_q       <= '0;
      resp_y_q   <= '0;
      resp_err_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= '0;
      drst_q     <= 1'b1;
      dstart_q   <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cur_q      <= cur_d;
      timer_q    <= timer_d;
      gnt_q      <= gnt_d;
      rv_q       <= rv_d;
      resp_y_q   <= resp_y_d;
      resp_err_q <= resp_err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      drst_q     <= drst_d;
      dstart_q   <= dstart_d;
      a_q        <= a_d;
      b_q        <= b_d;
    end
  end

  assign gnt        = gnt_q;
  assign resp_valid = rv_q;
  assign resp_y     = resp_y_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;
  assign done_cnt   = done_q;
  assign dut_rst    = drst_q;
  assign dut_start  = dstart_q;
  assign dut_a      = a_q;
  assign dut_b      = b_q;

endmodule

// File: tb/tb_a_sqrtb_arbiter.sv
// Scoreboard bench for a_sqrtb_arbiter: instance 0 (TIMEOUT=40) and instance 1 (TIMEOUT=8),
// each driving a behavioural a*isqrt(b) datapath with programmable latency.
module tb_a_sqrtb_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        rst_s      [2];
  logic [3:0]  req        [2];
  logic [31:0] req_a      [2];
  logic [31:0] req_b      [2];
  logic [3:0]  gnt        [2];
  logic [3:0]  resp_valid [2];
  logic [11:0] resp_y     [2];
  logic        resp_err   [2];
  logic        busy       [2];
  logic [15:0] done_cnt   [2];
  logic        dut_rst    [2];
  logic        dut_start  [2];
  logic [7:0]  dut_a      [2];
  logic [7:0]  dut_b      [2];
  logic [11:0] dut_y      [2];
  logic        dut_ready  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    a_sqrtb_arbiter #(.N(4), .TIMEOUT(g == 0 ? 40 : 8)) u_dut (
      .clk        (clk),
      .rst        (rst_s[g]),
      .req        (req[g]),
      .req_a      (req_a[g]),
      .req_b      (req_b[g]),
      .gnt        (gnt[g]),
      .resp_valid (resp_valid[g]),
      .resp_y     (resp_y[g]),
      .resp_err   (resp_err[g]),
      .busy       (busy[g]),
      .done_cnt   (done_cnt[g]),
      .dut_rst    (dut_rst[g]),
      .dut_start  (dut_start[g]),
      .dut_a      (dut_a[g]),
      .dut_b      (dut_b[g]),
      .dut_y      (dut_y[g]),
      .dut_ready  (dut_ready[g])
    );
  end

  function automatic int isqrt(int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic int oh2i(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Datapath model: lat = cycles after start before y_ready rises; 0 = never ready.
  int lat  [2];
  int mcnt [2];
  bit mbsy [2];
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (dut_rst[g]) begin
        mbsy[g]      <= 1'b0;
        mcnt[g]      <= 0;
        dut_ready[g] <= 1'b0;
        dut_y[g]     <= '0;
      end else if (dut_start[g]) begin
        mbsy[g] <= (lat[g] != 0);
        mcnt[g] <= lat[g];
      end else if (mbsy[g]) begin
        mcnt[g] <= mcnt[g] - 1;
        if (mcnt[g] == 1) begin
          dut_ready[g] <= 1'b1;
          dut_y[g]     <= 12'(int'(dut_a[g]) * isqrt(int'(dut_b[g])));
          mbsy[g]      <= 1'b0;
        end
      end
    end
  end

  typedef struct {
    int d;
    int idx;
    int y;
    int err;
    int lat;
    int cnt;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];
  int n_checks = 0;
  int n_fail   = 0;
  int expcnt [2];
  int tg     [2];
  int ph     [2];

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  task automatic expect_job(int d, int idx, int y, int err, int l);
    exp_t e;
    e.d = d; e.idx = idx; e.y = y; e.err = err; e.lat = l; e.cnt = 0;
    gq.push_back(e);
    expcnt[d]++;
    e.cnt = expcnt[d] & 32'hFFFF;
    rq.push_back(e);
  endtask

  task automatic expect_grant_only(int d, int idx);
    exp_t e;
    e.d = d; e.idx = idx; e.y = 0; e.err = 0; e.lat = 0; e.cnt = 0;
    gq.push_back(e);
  endtask

  task automatic set_op(int d, int i, logic [7:0] a, logic [7:0] b);
    req_a[d][8*i +: 8] = a;
    req_b[d][8*i +: 8] = b;
  endtask

  task automatic chk_reset(int d);
    check("rst_gnt",        32'(gnt[d]), 0);
    check("rst_resp_valid", 32'(resp_valid[d]), 0);
    check("rst_resp_y",     32'(resp_y[d]), 0);
    check("rst_resp_err",   32'(resp_err[d]), 0);
    check("rst_busy",       32'(busy[d]), 0);
    check("rst_done_cnt",   32'(done_cnt[d]), 0);
    check("rst_dut_rst",    32'(dut_rst[d]), 1);
    check("rst_dut_start",  32'(dut_start[d]), 0);
    check("rst_dut_a",      32'(dut_a[d]), 0);
    check("rst_dut_b",      32'(dut_b[d]), 0);
  endtask

  task automatic do_reset(int d);
    @(negedge clk);
    rst_s[d] = 1'b1;
    #1 chk_reset(d);
    @(negedge clk);
    rst_s[d] = 1'b0;
    expcnt[d] = 0;
  endtask

  task automatic wait_gnt(int d, output int idx);
    idx = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (gnt[d] != 0) begin
        idx = oh2i(gnt[d]);
        req[d][idx] = 1'b0;
        return;
      end
    end
    fail_now("gnt_wait_timeout");
  endtask

  task automatic wait_resp(int d);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (resp_valid[d] != 0) return;
    end
    fail_now("resp_wait_timeout");
  endtask

  // Monitor: pops the scoreboard on each grant / response and checks pulse sequencing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst_s[d]) begin
          ph[d] = 0;
          continue;
        end
        if (ph[d] == 1) begin
          check("start_pulse", 32'(dut_start[d]), 1);
          check("rst_dropped", 32'(dut_rst[d]), 0);
          ph[d] = 2;
        end else if (ph[d] == 2) begin
          check("start_dropped", 32'(dut_start[d]), 0);
          ph[d] = 0;
        end
        if (gnt[d] != 0) begin
          check("gnt_onehot", 32'($onehot(gnt[d])), 1);
          check("gnt_dut_rst", 32'(dut_rst[d]), 1);
          check("gnt_busy", 32'(busy[d]), 1);
          ph[d] = 1;
          tg[d] = cyc;
          if (gq.size() == 0) fail_now("unexpected_grant");
          else begin
            e = gq.pop_front();
            check("gnt_dut_sel", d, e.d);
            check("gnt_idx", oh2i(gnt[d]), e.idx);
          end
        end
        if (resp_valid[d] != 0) begin
          check("resp_onehot", 32'($onehot(resp_valid[d])), 1);
          if (rq.size() == 0) fail_now("unexpected_resp");
          else begin
            e = rq.pop_front();
            check("resp_dut_sel", d, e.d);
            check("resp_idx", oh2i(resp_valid[d]), e.idx);
            check("resp_y", 32'(resp_y[d]), e.y);
            check("resp_err", 32'(resp_err[d]), e.err);
            check("resp_latency", cyc - tg[d], e.lat);
            check("done_cnt", 32'(done_cnt[d]), e.cnt);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit (t=%0t)", $time);
    $fatal(1, "time limit");
  end

  initial begin
    int idx;
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; req[d] = '0; req_a[d] = '0; req_b[d] = '0;
      lat[d] = 0; expcnt[d] = 0; tg[d] = 0; ph[d] = 0;
    end
    repeat (2) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    @(negedge clk);
    check("idle_dut_rst0", 32'(dut_rst[0]), 0);
    check("idle_dut_rst1", 32'(dut_rst[1]), 0);

    // Single job: 16 * sqrt(64) = 128, ready 10 cycles after start
    lat[0] = 10;
    set_op(0, 0, 8'd16, 8'd64);
    expect_job(0, 0, 128, 0, 13);
    req[0] = 4'b0001;
    wait_gnt(0, idx);
    wait_resp(0);

    // Round-robin from reset: 0,1,2,3,0
    do_reset(0);
    lat[0] = 2;
    set_op(0, 0, 8'd1, 8'd1);
    set_op(0, 1, 8'd2, 8'd4);
    set_op(0, 2, 8'd3, 8'd9);
    set_op(0, 3, 8'd4, 8'd16);
    expect_job(0, 0, 1, 0, 5);
    expect_job(0, 1, 4, 0, 5);
    expect_job(0, 2, 9, 0, 5);
    expect_job(0, 3, 16, 0, 5);
    expect_job(0, 0, 1, 0, 5);
    req[0] = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_gnt(0, idx);
      if (j == 4) req[0] = '0;
      wait_resp(0);
      if (j < 4 && idx >= 0) begin
        @(negedge clk);
        req[0][idx] = 1'b1;
      end
    end

    // Fairness with wrap: grant 2, then 0101 must serve 0 before 2
    set_op(0, 2, 8'd5, 8'd25);
    set_op(0, 0, 8'd10, 8'd100);
    expect_job(0, 2, 25, 0, 5);
    expect_job(0, 0, 100, 0, 5);
    expect_job(0, 2, 25, 0, 5);
    req[0] = 4'b0100;
    wait_gnt(0, idx);
    wait_resp(0);
    req[0] = 4'b0101;
    wait_gnt(0, idx);
    wait_resp(0);
    wait_gnt(0, idx);
    wait_resp(0);

    // Instance 1 (TIMEOUT=8): stuck ready, normal job, simultaneous, one-late
    lat[1] = 0;
    set_op(1, 0, 8'd7, 8'd49);
    expect_job(1, 0, 0, 1, 10);
    req[1] = 4'b0001;
    wait_gnt(1, idx);
    wait_resp(1);
    lat[1] = 3;
    set_op(1, 1, 8'd9, 8'd81);
    expect_job(1, 1, 81, 0, 6);
    req[1] = 4'b0010;
    wait_gnt(1, idx);
    wait_resp(1);
    lat[1] = 7;
    set_op(1, 2, 8'd200, 8'd255);
    expect_job(1, 2, 3000, 0, 10);
    req[1] = 4'b0100;
    wait_gnt(1, idx);
    wait_resp(1);
    lat[1] = 8;
    set_op(1, 3, 8'd11, 8'd36);
    expect_job(1, 3, 0, 1, 10);
    req[1] = 4'b1000;
    wait_gnt(1, idx);
    wait_resp(1);

    // Async reset in the middle of WAIT aborts the job without a response
    lat[0] = 30;
    set_op(0, 1, 8'd3, 8'd4);
    expect_grant_only(0, 1);
    req[0] = 4'b0010;
    wait_gnt(0, idx);
    repeat (6) @(negedge clk);
    #2 rst_s[0] = 1'b1;
    #1 chk_reset(0);
    repeat (3) @(negedge clk);
    rst_s[0] = 1'b0;
    expcnt[0] = 0;
    lat[0] = 2;
    set_op(0, 0, 8'd12, 8'd144);
    set_op(0, 3, 8'd1, 8'd0);
    expect_job(0, 0, 144, 0, 5);
    req[0] = 4'b1001;
    wait_gnt(0, idx);
    req[0] = '0;
    wait_resp(0);

    repeat (4) @(negedge clk);
    check("grant_queue_drained", gq.size(), 0);
    check("resp_queue_drained", rq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
